// File: rtl/counter_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// counter_sweep_ctrl
//
// Sequencer for a WIDTH-bit up/down loadable counter (CE/SCLR/UP/LOAD/L/Q).
// A sweep command (start, end, mode, repeat count) is accepted over a
// valid/ready handshake. The controller then loads the counter with start,
// lets it count to end (up, down, or up-then-down "triangle"), repeats the
// sweep reps times, clears the counter and reports completion.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   cmd_valid  command present
//   cmd_ready  controller can accept a command (high only in IDLE)
//   cmd_start  sweep start value
//   cmd_end    sweep end value
//   cmd_mode   0=up, 1=down, 2=triangle, 3=reserved (illegal)
//   cmd_reps   number of sweeps, 0 is illegal
//   abort      terminate the active sweep (honoured in LOAD/RUN_UP/RUN_DOWN)
//   cnt_q      counter Q feedback
//   cnt_ce     counter CE    (combinational decode of state and cnt_q)
//   cnt_sclr   counter SCLR  (combinational decode of state)
//   cnt_up     counter UP    (combinational decode of state)
//   cnt_load   counter LOAD  (combinational decode of state)
//   cnt_l      counter L, the latched start value while a command is active
//   busy       high in any state except IDLE
//   done       one-cycle pulse at the end of every accepted legal command
//   aborted    qualifies done: 1 if the command was terminated by abort
//   err        one-cycle pulse after an illegal command is accepted
//   sweep_cnt  completed sweeps of the current/last command
//   state_dbg  current FSM state encoding (debug visibility)
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready is only high in IDLE, so cmd_valid
// presented while busy simply waits (or is withdrawn) without effect.
// ---------------------------------------------------------------------------
module counter_sweep_ctrl #(
  parameter int WIDTH = 32,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_end,
  input  logic [1:0]       cmd_mode,
  input  logic [REP_W-1:0] cmd_reps,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_ce,
  output logic             cnt_sclr,
  output logic             cnt_up,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_l,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err,
  output logic [REP_W-1:0] sweep_cnt,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_RUN_UP   = 3'd2,
    S_RUN_DOWN = 3'd3,
    S_CLEAR    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_TRI  = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   start_r;
  logic [WIDTH-1:0]   end_r;
  logic [1:0]         mode_r;
  logic [REP_W-1:0]   reps_r;
  logic [REP_W-1:0]   sweep_r;
  logic               abort_lat;
  logic               cmd_ready_r;
  logic               busy_r;
  logic               done_r;
  logic               aborted_r;
  logic               err_r;

  // -------------------------------------------------------------------------
  // Command decode
  // -------------------------------------------------------------------------
  logic accept;
  logic illegal;

  assign accept = cmd_valid && cmd_ready_r;

  // The range checks guarantee the counter walks monotonically from start
  // toward end without passing through the wrap point.
  always_comb begin
    illegal = 1'b0;
    if (cmd_mode == MODE_RSVD) begin
      illegal = 1'b1;
    end else if (cmd_reps == '0) begin
      illegal = 1'b1;
    end else if ((cmd_mode == MODE_UP || cmd_mode == MODE_TRI) && (cmd_end < cmd_start)) begin
      illegal = 1'b1;
    end else if ((cmd_mode == MODE_DOWN) && (cmd_end > cmd_start)) begin
      illegal = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Sweep progress
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] down_target;
  logic             at_end;
  logic             at_target;
  logic [REP_W-1:0] sweep_inc;
  logic             last_sweep;

  // A triangle sweep turns around at end and comes back to start; a plain
  // down sweep runs from start to end.
  assign down_target = (mode_r == MODE_TRI) ? start_r : end_r;
  assign at_end      = (cnt_q == end_r);
  assign at_target   = (cnt_q == down_target);
  assign sweep_inc   = sweep_r + {{(REP_W-1){1'b0}}, 1'b1};
  assign last_sweep  = (sweep_inc == reps_r);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  logic in_sweep;
  logic abort_take;
  logic sweep_done;

  assign in_sweep   = (state == S_LOAD) || (state == S_RUN_UP) || (state == S_RUN_DOWN);
  assign abort_take = abort && in_sweep;

  always_comb begin
    state_nxt  = state;
    sweep_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && !illegal) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_nxt = S_CLEAR;
        end else if (mode_r == MODE_DOWN) begin
          state_nxt = S_RUN_DOWN;
        end else begin
          state_nxt = S_RUN_UP;
        end
      end
      S_RUN_UP: begin
        // abort takes priority over a completion seen in the same cycle
        if (abort) begin
          state_nxt = S_CLEAR;
        end else if (at_end) begin
          if (mode_r == MODE_TRI) begin
            // reaching the top is only half of a triangle sweep
            state_nxt = S_RUN_DOWN;
          end else begin
            sweep_done = 1'b1;
            state_nxt  = last_sweep ? S_CLEAR : S_LOAD;
          end
        end
      end
      S_RUN_DOWN: begin
        if (abort) begin
          state_nxt = S_CLEAR;
        end else if (at_target) begin
          sweep_done = 1'b1;
          if (last_sweep) begin
            state_nxt = S_CLEAR;
          end else if (mode_r == MODE_TRI) begin
            // the counter already sits at start: no reload needed
            state_nxt = S_RUN_UP;
          end else begin
            state_nxt = S_LOAD;
          end
        end
      end
      S_CLEAR: begin
        state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Counter control decode (combinational from state and cnt_q)
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_ce   = 1'b0;
    cnt_sclr = 1'b0;
    cnt_up   = 1'b0;
    cnt_load = 1'b0;
    case (state)
      S_LOAD: begin
        cnt_ce   = 1'b1;
        cnt_load = 1'b1;
      end
      S_RUN_UP: begin
        cnt_ce = !at_end;
        cnt_up = 1'b1;
      end
      S_RUN_DOWN: begin
        cnt_ce = !at_target;
      end
      S_CLEAR: begin
        cnt_ce   = 1'b1;
        cnt_sclr = 1'b1;
      end
      default: begin
        cnt_ce   = 1'b0;
      end
    endcase
  end

  // L is only meaningful while a command is active; hold it at zero in IDLE
  // so an idle controller presents all-quiet pins to the counter.
  assign cnt_l = (state != S_IDLE) ? start_r : '0;

  // -------------------------------------------------------------------------
  // State and status registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      start_r     <= '0;
      end_r       <= '0;
      mode_r      <= '0;
      reps_r      <= '0;
      sweep_r     <= '0;
      abort_lat   <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      aborted_r   <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cmd_ready_r <= (state_nxt == S_IDLE);
      busy_r      <= (state_nxt != S_IDLE);
      done_r      <= (state_nxt == S_DONE);
      // abort_lat is already settled by the time CLEAR hands over to DONE
      aborted_r   <= (state_nxt == S_DONE) && abort_lat;
      err_r       <= accept && illegal;

      if (accept) begin
        start_r   <= cmd_start;
        end_r     <= cmd_end;
        mode_r    <= cmd_mode;
        reps_r    <= cmd_reps;
        sweep_r   <= '0;
        abort_lat <= 1'b0;
      end else begin
        if (abort_take) begin
          abort_lat <= 1'b1;
        end
        // saturate at reps; the count then holds until the next accept
        if (sweep_done && (sweep_r != reps_r)) begin
          sweep_r <= sweep_inc;
        end
      end
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign aborted   = aborted_r;
  assign err       = err_r;
  assign sweep_cnt = sweep_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// Directed bench for counter_sweep_ctrl. A behavioural model of the
// up/down loadable counter closes the loop on cnt_q. Expected values are
// hand-derived from the sweep description; outputs are sampled 1 ns after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_counter_sweep_ctrl;

  localparam int WIDTH = 32;
  localparam int REP_W = 8;

  // state encodings as seen on state_dbg
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_UP     = 3'd2;
  localparam logic [2:0] ST_DOWN   = 3'd3;
  localparam logic [2:0] ST_CLEAR  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_start;
  logic [WIDTH-1:0] cmd_end;
  logic [1:0]       cmd_mode;
  logic [REP_W-1:0] cmd_reps;
  logic             abort;
  logic [WIDTH-1:0] cnt_q;
  logic             cnt_ce;
  logic             cnt_sclr;
  logic             cnt_up;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_l;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             err;
  logic [REP_W-1:0] sweep_cnt;
  logic [2:0]       state_dbg;

  int total = 0;
  int bad   = 0;

  int done_cnt = 0;
  int err_cnt  = 0;
  int ce_cnt   = 0;
  int load_cnt = 0;

  int tri_q [16] = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1, 2, 3, 3, 2, 1, 0};

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT
  counter_sweep_ctrl #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_start (cmd_start),
    .cmd_end   (cmd_end),
    .cmd_mode  (cmd_mode),
    .cmd_reps  (cmd_reps),
    .abort     (abort),
    .cnt_q     (cnt_q),
    .cnt_ce    (cnt_ce),
    .cnt_sclr  (cnt_sclr),
    .cnt_up    (cnt_up),
    .cnt_load  (cnt_load),
    .cnt_l     (cnt_l),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .err       (err),
    .sweep_cnt (sweep_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------- counter model
  logic [WIDTH-1:0] q_model = '0;
  assign cnt_q = q_model;

  always @(posedge clk) begin
    if (cnt_ce) begin
      if (cnt_sclr)      q_model <= '0;
      else if (cnt_load) q_model <= cnt_l;
      else if (cnt_up)   q_model <= q_model + 1;
      else               q_model <= q_model - 1;
    end
  end

  // ---------------------------------------------------------------- monitors
  always @(negedge clk) begin
    if (done)     done_cnt++;
    if (err)      err_cnt++;
    if (cnt_ce)   ce_cnt++;
    if (cnt_load) load_cnt++;
  end

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present one command for exactly one accepting edge
  task automatic send(input logic [31:0] s, input logic [31:0] e,
                      input logic [1:0] m, input logic [7:0] r);
    cmd_start = s;
    cmd_end   = e;
    cmd_mode  = m;
    cmd_reps  = r;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int d0;
    int e0;
    int c0;
    int l0;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_start = '0;
    cmd_end   = '0;
    cmd_mode  = '0;
    cmd_reps  = '0;
    abort     = 1'b0;

    // ---- reset state
    tick();
    tick();
    chk("rst_ready",   cmd_ready, 1);
    chk("rst_busy",    busy,      0);
    chk("rst_done",    done,      0);
    chk("rst_err",     err,       0);
    chk("rst_aborted", aborted,   0);
    chk("rst_sweep",   sweep_cnt, 0);
    chk("rst_ce",      cnt_ce,    0);
    chk("rst_l",       cnt_l,     0);
    chk("rst_state",   state_dbg, ST_IDLE);
    rst = 1'b0;
    tick();

    // ---- up sweep 5..8, one rep
    d0 = done_cnt;
    send(5, 8, 2'd0, 1);
    chk("up_load_state", state_dbg, ST_LOAD);
    chk("up_load_ce",    cnt_ce,    1);
    chk("up_load_pin",   cnt_load,  1);
    chk("up_load_l",     cnt_l,     5);
    chk("up_busy",       busy,      1);
    chk("up_ready",      cmd_ready, 0);
    for (int v = 5; v < 8; v++) begin
      tick();
      chk("up_q",  cnt_q,  v);
      chk("up_ce", cnt_ce, 1);
      chk("up_up", cnt_up, 1);
    end
    tick();
    chk("up_q_end",    cnt_q,     8);
    chk("up_ce_end",   cnt_ce,    0);
    chk("up_state_end", state_dbg, ST_UP);
    tick();
    chk("up_clr_sclr",  cnt_sclr,  1);
    chk("up_clr_ce",    cnt_ce,    1);
    chk("up_clr_sweep", sweep_cnt, 1);
    chk("up_clr_done",  done,      0);
    tick();
    chk("up_done",      done,      1);
    chk("up_aborted",   aborted,   0);
    chk("up_q_cleared", cnt_q,     0);
    tick();
    chk("up_done_low",  done,      0);
    chk("up_idle_rdy",  cmd_ready, 1);
    chk("up_idle_busy", busy,      0);
    chk("up_sweep_hold", sweep_cnt, 1);
    chk("up_idle_l",    cnt_l,     0);
    chk("up_done_count", done_cnt, d0 + 1);

    // ---- down sweep 10..7, three reps
    d0 = done_cnt;
    send(10, 7, 2'd1, 3);
    chk("dn_load_l",  cnt_l,  10);
    chk("dn_load_up", cnt_up, 0);
    for (int r = 1; r <= 3; r++) begin
      for (int v = 10; v > 7; v--) begin
        tick();
        chk("dn_q",  cnt_q,  v);
        chk("dn_ce", cnt_ce, 1);
        chk("dn_up", cnt_up, 0);
      end
      tick();
      chk("dn_q_end",  cnt_q,  7);
      chk("dn_ce_end", cnt_ce, 0);
      tick();
      if (r < 3) begin
        chk("dn_reload", cnt_load,  1);
        chk("dn_sweep",  sweep_cnt, r);
      end else begin
        chk("dn_clr",       cnt_sclr,  1);
        chk("dn_sweep_fin", sweep_cnt, 3);
      end
    end
    tick();
    chk("dn_done",    done,    1);
    chk("dn_aborted", aborted, 0);
    tick();
    chk("dn_done_count", done_cnt, d0 + 1);

    // ---- triangle 0..3, two reps
    l0 = load_cnt;
    send(0, 3, 2'd2, 2);
    chk("tri_load", cnt_load, 1);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("tri_q",  cnt_q,  tri_q[i]);
      chk("tri_up", cnt_up, ((i / 4) % 2 == 0) ? 1 : 0);
      if (i == 8) chk("tri_sweep_mid", sweep_cnt, 1);
    end
    tick();
    chk("tri_clr",   cnt_sclr,  1);
    chk("tri_sweep", sweep_cnt, 2);
    tick();
    chk("tri_done", done, 1);
    tick();
    chk("tri_single_load", load_cnt, l0 + 1);

    // ---- illegal commands
    d0 = done_cnt;
    e0 = err_cnt;
    c0 = ce_cnt;
    send(0, 5, 2'd3, 1);
    chk("ill_mode3_err",   err,       1);
    chk("ill_mode3_state", state_dbg, ST_IDLE);
    chk("ill_mode3_ready", cmd_ready, 1);
    chk("ill_mode3_busy",  busy,      0);
    tick();
    chk("ill_err_pulse", err, 0);
    send(0, 5, 2'd0, 0);
    chk("ill_reps0_err", err, 1);
    tick();
    send(9, 4, 2'd0, 1);
    chk("ill_up_rev_err", err, 1);
    tick();
    send(4, 9, 2'd1, 1);
    chk("ill_dn_rev_err", err, 1);
    tick();
    chk("ill_err_count",  err_cnt,  e0 + 4);
    chk("ill_no_ce",      ce_cnt,   c0);
    chk("ill_no_done",    done_cnt, d0);

    // ---- start == end: zero counting cycles
    send(32'h20, 32'h20, 2'd0, 1);
    chk("eq_load", cnt_load, 1);
    chk("eq_err",  err,      0);
    tick();
    chk("eq_q",     cnt_q,     32'h20);
    chk("eq_ce",    cnt_ce,    0);
    chk("eq_state", state_dbg, ST_UP);
    tick();
    chk("eq_clr",   cnt_sclr,  1);
    chk("eq_sweep", sweep_cnt, 1);
    tick();
    chk("eq_done",  done,      1);
    tick();

    // ---- abort during an up sweep, with a competing command held
    send(32'h100, 32'h1FF, 2'd0, 4);
    tick();
    cmd_start = 32'h1;
    cmd_end   = 32'h2;
    cmd_mode  = 2'd0;
    cmd_reps  = 8'd1;
    cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("ab_ready_low", cmd_ready, 0);
    end
    chk("ab_q",      cnt_q, 32'h105);
    chk("ab_l_kept", cnt_l, 32'h100);
    cmd_valid = 1'b0;
    abort     = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_state", state_dbg, ST_CLEAR);
    chk("ab_sclr",  cnt_sclr,  1);
    chk("ab_sweep", sweep_cnt, 0);
    tick();
    chk("ab_done",    done,      1);
    chk("ab_aborted", aborted,   1);
    chk("ab_sweep_d", sweep_cnt, 0);
    tick();
    chk("ab_idle",    state_dbg, ST_IDLE);
    chk("ab_ab_low",  aborted,   0);

    // ---- reset in the middle of RUN_UP
    send(0, 100, 2'd0, 1);
    tick();
    tick();
    tick();
    tick();
    chk("rr_q_before", cnt_q, 3);
    rst = 1'b1;
    #1;
    chk("rr_ce",    cnt_ce,    0);
    chk("rr_up",    cnt_up,    0);
    chk("rr_ready", cmd_ready, 1);
    chk("rr_busy",  busy,      0);
    chk("rr_state", state_dbg, ST_IDLE);
    chk("rr_sweep", sweep_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rr_q_kept", cnt_q, 3);
    send(2, 4, 2'd0, 1);
    chk("rr2_load", cnt_load, 1);
    chk("rr2_l",    cnt_l,    2);
    tick();
    chk("rr2_q2", cnt_q, 2);
    tick();
    chk("rr2_q3", cnt_q, 3);
    tick();
    chk("rr2_q4",  cnt_q,  4);
    chk("rr2_ce4", cnt_ce, 0);
    tick();
    chk("rr2_clr", cnt_sclr, 1);
    tick();
    chk("rr2_done",  done,      1);
    chk("rr2_sweep", sweep_cnt, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
